// File: rtl/prbs16_pkg.sv
// prbs16_pkg: shared LFSR constants, state encoding and checker defaults
// for the x^16+x^14+x^13+x^11+1 PRBS generator/checker pair.
package prbs16_pkg;
    localparam int LFSR_W = 16;
    // s16, s14, s13, s11 with s[1] stored at bit 0
    localparam logic [LFSR_W-1:0] TAP_MASK = 16'hB400;
    localparam logic ESC_BIT = 1'b1;
    localparam int LOCK_MATCHES_DEF = 16;
    localparam int WIN_LEN_DEF = 64;
    localparam int WIN_ERR_MAX_DEF = 8;
    localparam int CNT_W_DEF = 12;
    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;
endpackage

// File: rtl/prbs16_next.sv
// prbs16_next: next LFSR bit from the current register, forcing a 1
// out of the all-zero state so the sequence can never stall.
module prbs16_next
    import prbs16_pkg::*;
(
    input  logic [LFSR_W-1:0] i_s,
    output logic              o_bit
);
    assign o_bit = (i_s == '0) ? ESC_BIT : ^(i_s & TAP_MASK);
endmodule

// File: rtl/prbs16_checker.sv
// prbs16_checker: self-synchronising PRBS16 checker on an 8-bit pad bus;
// locks onto the received stream and counts bit errors while locked.
module prbs16_checker
    import prbs16_pkg::*;
#(
    parameter int LOCK_MATCHES = LOCK_MATCHES_DEF,
    parameter int WIN_LEN      = WIN_LEN_DEF,
    parameter int WIN_ERR_MAX  = WIN_ERR_MAX_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);
    localparam int MW = $clog2(LOCK_MATCHES + 1);
    localparam int WW = $clog2(WIN_LEN + 1);
    localparam int EW = $clog2((WIN_ERR_MAX > WIN_LEN ? WIN_ERR_MAX : WIN_LEN) + 1);

    logic w_clk, w_rst, w_rx, w_vld, w_clr, w_sel, w_p, w_miss, w_wrap, w_unused;
    logic [11:0] w_disp;
    state_t r_state;
    logic [LFSR_W-1:0] r_s;
    logic [3:0] r_fill;
    logic [MW-1:0] r_match;
    logic [WW-1:0] r_win;
    logic [EW-1:0] r_werr;
    logic [CNT_W-1:0] r_cnt;
    logic r_pulse;

    assign w_clk = io_in[0];
    assign w_rst = io_in[1];
    assign w_rx = io_in[2];
    assign w_vld = io_in[3];
    assign w_clr = io_in[4];
    assign w_sel = io_in[5];
    assign w_unused = &{1'b0, io_in[7:6]};

    prbs16_next u_next (.i_s(r_s), .o_bit(w_p));

    assign w_miss = w_rx ^ w_p;
    assign w_wrap = (r_win == WW'(WIN_LEN - 1));

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_state <= SEARCH;
            r_s <= '0;
            r_fill <= '0;
            r_match <= '0;
            r_win <= '0;
            r_werr <= '0;
            r_cnt <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (w_vld) begin
                case (r_state)
                    SEARCH: begin
                        r_s <= {r_s[LFSR_W-2:0], w_rx};
                        r_fill <= r_fill + 4'd1;
                        if (r_fill == 4'd15) begin
                            r_state <= VERIFY;
                            r_match <= '0;
                        end
                    end
                    VERIFY: begin
                        r_s <= {r_s[LFSR_W-2:0], w_rx};
                        if (w_miss) begin
                            r_state <= SEARCH;
                            r_fill <= '0;
                        end else if (r_match == MW'(LOCK_MATCHES - 1)) begin
                            r_state <= LOCKED;
                            r_win <= '0;
                            r_werr <= '0;
                        end else begin
                            r_match <= r_match + MW'(1);
                        end
                    end
                    LOCKED: begin
                        // Feed back the prediction so a bad bit cannot corrupt later predictions
                        r_s <= {r_s[LFSR_W-2:0], w_p};
                        r_win <= w_wrap ? '0 : r_win + WW'(1);
                        r_werr <= w_wrap ? '0 : r_werr + EW'(w_miss);
                        if (w_miss) begin
                            r_pulse <= 1'b1;
                            if (r_cnt != '1)
                                r_cnt <= r_cnt + CNT_W'(1);
                            if (r_werr == EW'(WIN_ERR_MAX - 1)) begin
                                r_state <= SEARCH;
                                r_fill <= '0;
                            end
                        end
                    end
                    default: r_state <= SEARCH;
                endcase
            end
            if (w_clr)
                r_cnt <= '0;
        end
    end

    assign w_disp = 12'(r_cnt);
    assign io_out = {w_sel ? w_disp[11:6] : w_disp[5:0], r_pulse, r_state == LOCKED};
endmodule
